mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer for the data-memory access performed by the instruction held in the EX/MEM pipeline register. It decodes the stage-4 control bits, runs a req/ack transaction to a variable-latency data memory, and asserts `stall` to freeze the whole pipeline, EX/MEM included, until the access completes. Load data is captured for the MEM/WB register. Misaligned, conflicting or timed-out accesses raise a sticky fault.

## Interface
- `TIMEOUT`, default 16: maximum cycles in ACCESS without `dmem_ack` before a timeout fault; legal range 1..255.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `contral_out_b2`  in  3  EX/MEM control: [2]=Reg_w, [1]=Mem_w, [0]=Mem_r.
- `ALU_out_b`  in  32  effective byte address from EX/MEM.
- `RtData_b2`  in  32  store data from EX/MEM.
- `dmem_ack`  in  1  memory completion; honoured only while `dmem_req`=1.
- `dmem_rdata`  in  32  read data, valid with `dmem_ack` on reads.
- `dmem_req`  out  1  registered access request.
- `dmem_we`  out  1  registered; 1=write, 0=read.
- `dmem_addr`  out  32  registered word address (byte address, [1:0]=0).
- `dmem_wdata`  out  32  registered store data.
- `stall`  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM.
- `MemData_b3`  out  32  captured load data for MEM/WB.
- `fault`  out  1  sticky error flag.
- `fault_code`  out  2  01=misaligned, 10=timeout, 11=Mem_r and Mem_w both set.

## Operation
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE, `access` = Mem_r | Mem_w:
  - No access: remain in IDLE.
  - Mem_r and Mem_w both set: go to FAULT, code 11.
  - `ALU_out_b[1:0]`≠0: go to FAULT, code 01.
  - Otherwise: latch addr, wdata and `we`=Mem_w; set `dmem_req`=1; clear the counter; go to ACCESS.
  - When code 11 and misalignment coincide, code 11 wins.
- ACCESS:
  - `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` stay stable.
  - On `dmem_ack`: `dmem_req`←0; if read, `MemData_b3`←`dmem_rdata`; go to DONE.
  - No ack: the counter increments. When the counter = TIMEOUT-1 with no ack: `dmem_req`←0, go to FAULT with code 10.
  - Ack in the same cycle as the timeout: ack wins.
- DONE: lasts one cycle and always returns to IDLE. The control bits are not sampled in DONE, because EX/MEM still holds the completed instruction.
- FAULT: absorbing; only `rst` exits. `dmem_req`=0.
- `stall` = (IDLE & access) | ACCESS | FAULT. `stall` is 0 in DONE, so EX/MEM and MEM/WB advance at the end of DONE.
- `MemData_b3` holds its value except on a read ack. Writes never modify it.
- `dmem_ack` outside ACCESS is ignored.

## Timing
- Reset values: state=IDLE, all registered outputs 0, counter 0, `fault`=0, `fault_code`=00. `stall` follows from the state, so it is 0 unless `access` is asserted.
- Reset during ACCESS drops `dmem_req` immediately, asynchronously. No completion is reported.
- Access with ack at cycle k after `dmem_req` rises (k≥1): `stall` high for k+1 cycles (the IDLE detect cycle plus k ACCESS cycles), then low in DONE. The pipeline penalty is k+1 cycles.
- Minimum ack latency is 1 cycle, giving a stall of 2 cycles.
- Back-to-back memory instructions: the next one is detected in the IDLE cycle that follows DONE.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

## Structure
- Package `mem_ctrl_pkg`:
  - state enum;
  - fault code constants;
  - control bit indices (`REG_W`=2, `MEM_W`=1, `MEM_R`=0).
- Sub-module `mem_timeout_cnt`: clear, enable and `expired` outputs, parameterised by TIMEOUT.
- Top level: FSM, request and data registers, stall decode.

## Test plan
- Load, ack after 3 cycles: `contral_out_b2`=3'b101, addr 0x0000_0010, `dmem_rdata`=0xDEAD_BEEF. Required response: `stall` high for 4 cycles, `dmem_we`=0, `MemData_b3`=0xDEAD_BEEF in DONE.
- Store, ack after 1 cycle: 3'b010, addr 0x20, `RtData_b2`=0x1234_5678. Required response: `dmem_req` for 1 cycle, `dmem_we`=1, `dmem_wdata`=0x1234_5678, `MemData_b3` unchanged.
- Misaligned load: addr 0x0000_0013. Required response: no `dmem_req`, FAULT next cycle, `fault_code`=01, `stall` stuck at 1 until `rst`.
- Timeout: TIMEOUT=4, no ack. Required response: `dmem_req` drops after 4 ACCESS cycles, `fault_code`=10. An ack on the 4th cycle instead gives a normal completion.
- Two consecutive loads with immediate ack: exactly one DONE between them, and no request is re-issued for the first instruction.
- `rst` asserted in the second ACCESS cycle: outputs clear asynchronously and `stall`=0 with `contral_out_b2`=0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the EX/MEM data-memory access sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10,
    ST_FAULT  = 2'b11
  } state_e;

  localparam logic [1:0] FC_NONE        = 2'b00;
  localparam logic [1:0] FC_MISALIGN    = 2'b01;
  localparam logic [1:0] FC_TIMEOUT     = 2'b10;
  localparam logic [1:0] FC_RW_CONFLICT = 2'b11;

  localparam int REG_W = 2;
  localparam int MEM_W = 1;
  localparam int MEM_R = 0;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating wait counter for an outstanding memory request; flags the last allowed cycle.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: next-state gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences the EX/MEM data-memory access over a req/ack bus and stalls the pipeline meanwhile.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  contral_out_b2,
  input  logic [31:0] ALU_out_b,
  input  logic [31:0] RtData_b2,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic [31:0] MemData_b3,
  output logic        fault,
  output logic [1:0]  fault_code
);

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, mdata_q, mdata_d;
  logic        fault_q, fault_d;
  logic [1:0]  code_q, code_d;
  logic        cnt_clr, cnt_en, expired;

  logic mem_r, mem_w, access, unused_reg_w;
  assign mem_r        = contral_out_b2[MEM_R];
  assign mem_w        = contral_out_b2[MEM_W];
  assign access       = mem_r | mem_w;
  assign unused_reg_w = contral_out_b2[REG_W];

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mdata_d = mdata_q;
    fault_d = fault_q;
    code_d  = code_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Read/write conflict is checked before alignment so code 11 wins.
        if (access) begin
          if (mem_r && mem_w) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = FC_RW_CONFLICT;
          end else if (ALU_out_b[1:0] != 2'b00) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = FC_MISALIGN;
          end else begin
            state_d = ST_ACCESS;
            req_d   = 1'b1;
            we_d    = mem_w;
            addr_d  = {ALU_out_b[31:2], 2'b00};
            wdata_d = RtData_b2;
            cnt_clr = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // An ack in the expiry cycle still completes normally.
        if (dmem_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          if (!we_q) mdata_d = dmem_rdata;
        end else if (expired) begin
          state_d = ST_FAULT;
          req_d   = 1'b0;
          fault_d = 1'b1;
          code_d  = FC_TIMEOUT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdata_q <= '0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mdata_q <= mdata_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  // DONE deliberately releases the stall so EX/MEM and MEM/WB advance.
  assign stall = ((state_q == ST_IDLE) && access) ||
                 (state_q == ST_ACCESS) || (state_q == ST_FAULT);

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign MemData_b3 = mdata_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: directed plan plus random transactions against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int TO  = 4;
  localparam int CAP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ctrl_drv;
  logic [31:0] alu_drv, rt_drv, rdata_drv;
  logic        ack_drv;
  logic        dmem_req, dmem_we, stall, fault;
  logic [31:0] dmem_addr, dmem_wdata, mem_data;
  logic [1:0]  fault_code;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_mdata;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .contral_out_b2 (ctrl_drv),
    .ALU_out_b      (alu_drv),
    .RtData_b2      (rt_drv),
    .dmem_ack       (ack_drv),
    .dmem_rdata     (rdata_drv),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .stall          (stall),
    .MemData_b3     (mem_data),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ctrl_drv = 3'b000;
    alu_drv  = '0;
    rt_drv   = '0;
    ack_drv  = 1'b0;
    repeat (2) @(negedge clk);
    rst         = 1'b0;
    model_mdata = '0;
  endtask

  // k = ack on the k-th cycle the request is seen high; k outside 1..TO never acks in time.
  task automatic run_txn(input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int k);
    int   n_stall = 0;
    int   n_req   = 0;
    int   exp_stall, exp_req;
    bit   exp_fault;
    logic [1:0] exp_code;
    bit   is_read, is_write;

    is_read   = ctrl[0];
    is_write  = ctrl[1];
    exp_fault = 1'b0;
    exp_code  = 2'b00;
    exp_req   = 0;
    exp_stall = 0;
    if (!(is_read || is_write)) begin
      exp_stall = 0;
    end else if (is_read && is_write) begin
      exp_fault = 1'b1; exp_code = 2'b11; exp_stall = CAP;
    end else if (addr[1:0] != 2'b00) begin
      exp_fault = 1'b1; exp_code = 2'b01; exp_stall = CAP;
    end else if (k >= 1 && k <= TO) begin
      exp_stall = k + 1; exp_req = k;
    end else begin
      exp_fault = 1'b1; exp_code = 2'b10; exp_stall = CAP; exp_req = TO;
    end

    @(posedge clk);
    #1;
    ctrl_drv  = ctrl;
    alu_drv   = addr;
    rt_drv    = wdata;
    rdata_drv = rdata;
    ack_drv   = 1'b0;

    for (int c = 0; c < CAP; c++) begin
      @(negedge clk);
      if (!stall) break;
      n_stall++;
      if (dmem_req) begin
        n_req++;
        check("req_we",    32'(dmem_we), 32'(is_write));
        check("req_addr",  dmem_addr, addr);
        check("req_wdata", dmem_wdata, wdata);
      end
      // Spurious acks while no request is outstanding must be ignored.
      ack_drv = dmem_req ? (n_req == k) : ($urandom_range(0, 3) == 0);
    end

    check("stall_len", n_stall, exp_stall);
    check("req_len",   n_req,   exp_req);
    if (!exp_fault && (is_read || is_write) && is_read) model_mdata = rdata;
    check("mem_data",  mem_data, model_mdata);
    check("fault",     32'(fault), 32'(exp_fault));
    check("fault_code", 32'(fault_code), 32'(exp_code));
    if (exp_fault) do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  c;
    logic [31:0] a;
    int          r, k;

    rdata_drv = '0;
    do_reset();
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req",   32'(dmem_req), 32'd0);
    check("rst_we",    32'(dmem_we), 32'd0);
    check("rst_addr",  dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_mdata", mem_data, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_code",  32'(fault_code), 32'd0);

    run_txn(3'b101, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 3);
    run_txn(3'b010, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_FFFF, 1);
    run_txn(3'b101, 32'h0000_0013, 32'h0,         32'h5555_5555, 1);
    run_txn(3'b001, 32'h0000_0040, 32'h0,         32'h0BAD_F00D, 0);
    run_txn(3'b001, 32'h0000_0044, 32'h0,         32'hCAFE_0004, TO);
    run_txn(3'b011, 32'h0000_0003, 32'h0,         32'h0,         1);
    run_txn(3'b001, 32'h0000_0100, 32'h0,         32'hAAAA_0001, 1);
    run_txn(3'b001, 32'h0000_0104, 32'h0,         32'hAAAA_0002, 1);
    run_txn(3'b000, 32'h0000_0108, 32'h0,         32'h0,         1);

    // Reset in the second ACCESS cycle drops the request without a clock edge.
    @(posedge clk);
    #1;
    ctrl_drv = 3'b001; alu_drv = 32'h0000_0200; ack_drv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("mid_req_up", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_req",   32'(dmem_req), 32'd0);
    check("arst_mdata", mem_data, 32'd0);
    check("arst_fault", 32'(fault), 32'd0);
    ctrl_drv = 3'b000;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_mdata = '0;

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      c = {1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01};
      a = $urandom & 32'hFFFF_FFFC;
      k = $urandom_range(1, TO);
      case (r)
        0: c[1:0] = 2'b00;
        1: c[1:0] = 2'b11;
        2: a[1:0] = 2'($urandom_range(1, 3));
        3: k = ($urandom_range(0, 1) != 0) ? 0 : TO + 1;
        default: ;
      endcase
      run_txn(c, a, $urandom, $urandom, k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
